// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU definitions used by the instruction-fetch stage: datapath widths,
// the NOP encoding presented as a bubble, and the fetch FSM state encoding.
package instr_fetch_unit_pkg;

  localparam int CPU_ADDRWIDTH = 32;
  localparam int CPU_WIDTH     = 32;
  localparam int OP_WIDTH      = 6;

  // All-zero opcode and operand field: the decode stage treats this as a NOP.
  localparam logic [CPU_WIDTH-1:0] NOP_INSTR =
    {{OP_WIDTH{1'b0}}, {(CPU_WIDTH - OP_WIDTH){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fetch_buf.sv
// Two-entry fetch FIFO. The head entry lives in its own register so the
// IF/ID outputs come straight from flops; an empty FIFO holds EMPTY_VAL in
// the head so the consumer sees a bubble without any output muxing.
module fetch_buf #(
  parameter int            DW        = 64,
  parameter logic [DW-1:0] EMPTY_VAL = '0
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clear_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] head_o,
  output logic [1:0]    occ_o
);

  logic [DW-1:0] head_q;
  logic [DW-1:0] tail_q;
  logic [1:0]    occ_q;
  logic          pop_ok;

  // A pop request against an empty FIFO is ignored.
  assign pop_ok = pop_i & (occ_q != 2'd0);
  assign head_o = head_q;
  assign occ_o  = occ_q;

  // Entry storage and occupancy; clear wins over push/pop.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q <= EMPTY_VAL;
      tail_q <= EMPTY_VAL;
      occ_q  <= 2'd0;
    end else if (clear_i) begin
      head_q <= EMPTY_VAL;
      tail_q <= EMPTY_VAL;
      occ_q  <= 2'd0;
    end else begin
      case ({push_i, pop_ok})
        2'b11: begin
          // Occupancy unchanged; the new word replaces whatever left.
          if (occ_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= din_i;
          end else begin
            head_q <= din_i;
          end
        end
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_q <= din_i;
          end else if (occ_q == 2'd1) begin
            tail_q <= din_i;
          end
          // A push into a full FIFO is dropped rather than corrupting state.
          if (occ_q != 2'd2) begin
            occ_q <= occ_q + 2'd1;
          end
        end
        2'b01: begin
          head_q <= (occ_q == 2'd2) ? tail_q : EMPTY_VAL;
          tail_q <= EMPTY_VAL;
          occ_q  <= occ_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues at most one outstanding
// instruction-memory request, buffers responses in a 2-entry FIFO and hands
// {instruction, PC+4} to the IF/ID register. Redirects flush the FIFO and
// any response still in flight is discarded in the DRAIN state.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                   ADDRWIDTH = CPU_ADDRWIDTH,
  parameter int                   WIDTH     = CPU_WIDTH,
  parameter logic [ADDRWIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 stall_i,
  input  logic                 redirect_i,
  input  logic [ADDRWIDTH-1:0] redirect_addr_i,
  output logic                 imem_req_o,
  output logic [ADDRWIDTH-1:0] imem_addr_o,
  input  logic                 imem_valid_i,
  input  logic [WIDTH-1:0]     imem_rdata_i,
  output logic [WIDTH-1:0]     ins_o,
  output logic [ADDRWIDTH-1:0] next_addr_o,
  output logic                 ins_valid_o
);

  localparam int EW = WIDTH + ADDRWIDTH;

  fetch_state_e         state_q;
  logic [ADDRWIDTH-1:0] pc_q;
  logic [ADDRWIDTH-1:0] pc_plus4;
  logic [EW-1:0]        buf_head;
  logic [1:0]           buf_occ;
  logic [2:0]           occ_next;
  logic                 consume;
  logic                 capture;
  logic                 issue_ok;
  logic                 unused_redirect_lsbs;

  // Instruction fetches are word aligned; the low address bits carry nothing.
  assign unused_redirect_lsbs = ^redirect_addr_i[1:0];

  // pc_q always names the address of the pending (or next) request.
  assign pc_plus4    = pc_q + ADDRWIDTH'(4);
  assign ins_valid_o = (buf_occ != 2'd0);
  assign consume     = ins_valid_o & ~stall_i & ~redirect_i;
  assign capture     = imem_valid_i & (state_q == ST_WAIT) & ~redirect_i;
  assign occ_next    = {1'b0, buf_occ} - {2'b00, consume} + {2'b00, capture};
  // Only issue if a slot remains for the response this request will return.
  assign issue_ok    = (occ_next <= 3'd1) & ~redirect_i;

  // Request generation; in WAIT a capture can chain straight into the next fetch.
  always_comb begin
    imem_req_o  = 1'b0;
    imem_addr_o = pc_q;
    case (state_q)
      ST_ISSUE: imem_req_o = issue_ok;
      ST_WAIT: begin
        if (capture) begin
          imem_req_o  = issue_ok;
          imem_addr_o = pc_plus4;
        end
      end
      default: ;
    endcase
  end

  // Fetch FSM and PC; a redirect overrides every other transition.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else if (redirect_i) begin
      pc_q <= {redirect_addr_i[ADDRWIDTH-1:2], 2'b00};
      case (state_q)
        // If the outstanding response lands in the redirect cycle it is
        // dropped right here, so nothing is left to drain.
        ST_WAIT, ST_DRAIN: state_q <= imem_valid_i ? ST_ISSUE : ST_DRAIN;
        default:           state_q <= ST_ISSUE;
      endcase
    end else begin
      if (capture) begin
        pc_q <= pc_plus4;
      end
      case (state_q)
        ST_IDLE:  state_q <= ST_ISSUE;
        ST_ISSUE: if (imem_req_o) state_q <= ST_WAIT;
        ST_WAIT:  if (capture && !imem_req_o) state_q <= ST_ISSUE;
        ST_DRAIN: if (imem_valid_i) state_q <= ST_ISSUE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  fetch_buf #(
    .DW       (EW),
    .EMPTY_VAL({WIDTH'(NOP_INSTR), {ADDRWIDTH{1'b0}}})
  ) u_fetch_buf (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .push_i (capture),
    .pop_i  (consume),
    .clear_i(redirect_i),
    .din_i  ({imem_rdata_i, pc_plus4}),
    .head_o (buf_head),
    .occ_o  (buf_occ)
  );

  assign ins_o       = buf_head[EW-1:ADDRWIDTH];
  assign next_addr_o = buf_head[ADDRWIDTH-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a latency-configurable instruction memory plus a
// queue-based model of the fetched instruction stream.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_addr_i = 32'h0;
  logic        imem_valid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] ins_o;
  logic [31:0] next_addr_o;
  logic        ins_valid_o;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .ADDRWIDTH(32),
    .WIDTH    (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n_i),
    .stall_i        (stall_i),
    .redirect_i     (redirect_i),
    .redirect_addr_i(redirect_addr_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_valid_i   (imem_valid_i),
    .imem_rdata_i   (imem_rdata_i),
    .ins_o          (ins_o),
    .next_addr_o    (next_addr_o),
    .ins_valid_o    (ins_valid_o)
  );

  int checks = 0;
  int errors = 0;

  // memory model
  logic        mem_busy = 1'b0;
  logic        mem_live = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_cnt = 0;
  int          lat_cfg = 1;
  bit          lat_rand = 1'b0;
  logic [31:0] salt = 32'h0;

  // stream model and observations
  logic [63:0] fq[$];
  logic [63:0] cons_q[$];
  logic [31:0] req_q[$];
  int          req_cyc[$];
  logic [31:0] nxt_req = RST_PC;
  int          cyc = 0;
  int          mdl_err = 0;
  string       mdl_msg = "";

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // One clock: drive at negedge, observe and update the model, step memory.
  task automatic cycle(input logic st, input logic rd, input logic [31:0] ra, input logic rn);
    logic        req;
    logic        vld;
    logic [31:0] addr;
    logic [63:0] exp_h;
    @(negedge clk);
    rst_n_i = rn;
    stall_i = st;
    redirect_i = rd;
    redirect_addr_i = ra;
    vld = mem_busy && (mem_cnt == 0);
    imem_valid_i = vld;
    imem_rdata_i = vld ? word(mem_addr) : $urandom();
    #1;
    req = imem_req_o;
    addr = imem_addr_o;
    if (!rn) begin
      fq.delete();
      mem_live = 1'b0;
      nxt_req = RST_PC;
    end
    exp_h = (fq.size() > 0) ? fq[0] : 64'h0;
    if ({ins_o, next_addr_o} !== exp_h || ins_valid_o !== (fq.size() > 0)) begin
      mdl_err++;
      mdl_msg = $sformatf("cyc %0d head %h_%h vld %b, model %h vld %0d", cyc, ins_o,
                          next_addr_o, ins_valid_o, exp_h, fq.size() > 0);
    end
    if (req === 1'b1) begin
      if (!rn || rd) begin
        mdl_err++;
        mdl_msg = $sformatf("cyc %0d request during reset/redirect", cyc);
      end else if (addr !== nxt_req) begin
        mdl_err++;
        mdl_msg = $sformatf("cyc %0d req addr %h, model %h", cyc, addr, nxt_req);
      end else if (mem_busy && !vld) begin
        mdl_err++;
        mdl_msg = $sformatf("cyc %0d second outstanding request", cyc);
      end
    end
    if (rn) begin
      if (rd) begin
        fq.delete();
        mem_live = 1'b0;
        nxt_req = {ra[31:2], 2'b00};
      end else begin
        if (fq.size() > 0 && !st) cons_q.push_back(fq.pop_front());
        if (vld && mem_live) begin
          fq.push_back({word(mem_addr), mem_addr + 32'd4});
          mem_live = 1'b0;
        end
        if (fq.size() > 2) begin
          mdl_err++;
          mdl_msg = $sformatf("cyc %0d capture into full buffer", cyc);
        end
        if (req === 1'b1) begin
          if (fq.size() + 1 > 2) begin
            mdl_err++;
            mdl_msg = $sformatf("cyc %0d request without free slot", cyc);
          end
          nxt_req = addr + 32'd4;
        end
      end
    end
    if (req === 1'b1) begin
      req_q.push_back(addr);
      req_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (vld) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (req === 1'b1 && rn && !rd) begin
      mem_busy = 1'b1;
      mem_addr = addr;
      mem_cnt = (lat_rand ? int'($urandom_range(3, 1)) : lat_cfg) - 1;
      mem_live = 1'b1;
    end
  endtask

  task automatic do_reset(input int n);
    mdl_err = 0;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    req_q.delete();
    req_cyc.delete();
    cons_q.delete();
  endtask

  task automatic test_reset();
    lat_cfg = 1;
    lat_rand = 1'b0;
    do_reset(4);
    checks++;
    if (ins_o !== 32'h0) begin errors++; $display("FAIL reset_ins: got %h want 0", ins_o); end
    checks++;
    if (next_addr_o !== 32'h0) begin errors++; $display("FAIL reset_next_addr: got %h want 0", next_addr_o); end
    checks++;
    if (ins_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ins_valid_o); end
    checks++;
    if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req_o); end
    checks++;
    if (mdl_err !== 0) begin errors++; $display("FAIL reset_model: %0d mismatches, last %s", mdl_err, mdl_msg); end
  endtask

  task automatic test_stream();
    int gaps;
    int bad;
    bit seen;
    lat_cfg = 1;
    do_reset(4);
    gaps = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      if (seen && ins_valid_o !== 1'b1) gaps++;
      if (ins_valid_o === 1'b1) seen = 1'b1;
    end
    checks++;
    if (req_q.size() < 3 || req_q[0] !== 32'h0 || req_q[1] !== 32'h4 || req_q[2] !== 32'h8) begin
      errors++;
      $display("FAIL stream_req_addrs: got %0d reqs first %h want 0,4,8", req_q.size(),
               req_q.size() > 0 ? req_q[0] : 32'hx);
    end
    checks++;
    if (req_cyc.size() < 3 || req_cyc[1] != req_cyc[0] + 1 || req_cyc[2] != req_cyc[1] + 1) begin
      errors++;
      $display("FAIL stream_req_spacing: requests not on consecutive cycles");
    end
    bad = 0;
    for (int k = 0; k < cons_q.size(); k++)
      if (cons_q[k] !== {word(32'(4 * k)), 32'(4 * k + 4)}) bad++;
    checks++;
    if (cons_q.size() < 15 || bad != 0) begin
      errors++;
      $display("FAIL stream_words: got %0d consumed %0d wrong, want >=15 and 0 wrong", cons_q.size(), bad);
    end
    checks++;
    if (gaps != 0) begin errors++; $display("FAIL stream_valid_held: got %0d gaps want 0", gaps); end
    checks++;
    if (mdl_err !== 0) begin errors++; $display("FAIL stream_model: %0d mismatches, last %s", mdl_err, mdl_msg); end
  endtask

  task automatic test_latency3();
    int bad;
    lat_cfg = 3;
    do_reset(4);
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    bad = 0;
    for (int k = 1; k < req_cyc.size(); k++) if (req_cyc[k] != req_cyc[k-1] + 3) bad++;
    checks++;
    if (req_cyc.size() < 5 || bad != 0) begin
      errors++;
      $display("FAIL lat3_spacing: got %0d reqs %0d bad gaps, want every 3 cycles", req_cyc.size(), bad);
    end
    bad = 0;
    for (int k = 0; k < cons_q.size(); k++)
      if (cons_q[k] !== {word(32'(4 * k)), 32'(4 * k + 4)}) bad++;
    checks++;
    if (cons_q.size() < 8 || bad != 0) begin
      errors++;
      $display("FAIL lat3_words: got %0d consumed %0d wrong, want >=8 and 0 wrong", cons_q.size(), bad);
    end
    checks++;
    if (mdl_err !== 0) begin errors++; $display("FAIL lat3_model: %0d mismatches, last %s", mdl_err, mdl_msg); end
  endtask

  task automatic test_stall();
    int budget;
    int unstable;
    int nreq;
    int bad;
    logic [63:0] h0;
    lat_cfg = 1;
    do_reset(4);
    budget = 0;
    while (ins_valid_o !== 1'b1 && budget < 10) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      budget++;
    end
    h0 = {ins_o, next_addr_o};
    checks++;
    if (h0 !== {word(32'h0), 32'h4}) begin
      errors++;
      $display("FAIL stall_first_word: got %h want %h", h0, {word(32'h0), 32'h4});
    end
    nreq = req_q.size();
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      if ({ins_o, next_addr_o} !== h0 || ins_valid_o !== 1'b1) unstable++;
    end
    checks++;
    if (unstable != 0) begin errors++; $display("FAIL stall_head_stable: got %0d changes want 0", unstable); end
    checks++;
    if (req_q.size() != nreq) begin
      errors++;
      $display("FAIL stall_no_req: got %0d requests while full want 0", req_q.size() - nreq);
    end
    for (int i = 0; i < 15; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    bad = 0;
    for (int k = 0; k < cons_q.size(); k++)
      if (cons_q[k] !== {word(32'(4 * k)), 32'(4 * k + 4)}) bad++;
    checks++;
    if (cons_q.size() < 10 || bad != 0) begin
      errors++;
      $display("FAIL stall_order: got %0d consumed %0d wrong, want >=10 and 0 wrong", cons_q.size(), bad);
    end
    checks++;
    if (mdl_err !== 0) begin errors++; $display("FAIL stall_model: %0d mismatches, last %s", mdl_err, mdl_msg); end
  endtask

  task automatic test_redirect_drain();
    int budget;
    int i8;
    int c8;
    int ncons;
    int stale;
    lat_cfg = 3;
    do_reset(4);
    budget = 0;
    while ((req_q.size() == 0 || req_q[req_q.size()-1] !== 32'h8) && budget < 20) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
      budget++;
    end
    checks++;
    if (req_q.size() == 0 || req_q[req_q.size()-1] !== 32'h8) begin
      errors++;
      $display("FAIL drain_setup: no request to 0x8 within %0d cycles", budget);
      return;
    end
    i8 = req_q.size() - 1;
    c8 = req_cyc[i8];
    ncons = cons_q.size();
    cycle(1'b0, 1'b1, 32'h103, 1'b1);
    checks++;
    if (ins_valid_o !== 1'b0) begin errors++; $display("FAIL drain_flush: ins_valid_o=%b want 0", ins_valid_o); end
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (req_q.size() <= i8 + 1 || req_q[i8+1] !== 32'h100 || req_cyc[i8+1] != c8 + 4) begin
      errors++;
      $display("FAIL drain_next_req: got %h at cycle %0d want 100 at cycle %0d",
               req_q.size() > i8 + 1 ? req_q[i8+1] : 32'hx,
               req_cyc.size() > i8 + 1 ? req_cyc[i8+1] : -1, c8 + 4);
    end
    stale = 0;
    for (int k = ncons; k < cons_q.size(); k++) if (cons_q[k][31:0] === 32'hC) stale++;
    checks++;
    if (stale != 0) begin errors++; $display("FAIL drain_stale_dropped: got %0d stale words want 0", stale); end
    checks++;
    if (cons_q.size() <= ncons || cons_q[ncons] !== {word(32'h100), 32'h104}) begin
      errors++;
      $display("FAIL drain_target_word: got %h want %h",
               cons_q.size() > ncons ? cons_q[ncons] : 64'hx, {word(32'h100), 32'h104});
    end
    checks++;
    if (mdl_err !== 0) begin errors++; $display("FAIL drain_model: %0d mismatches, last %s", mdl_err, mdl_msg); end
  endtask

  task automatic test_redirect_capture();
    int budget;
    int rc;
    int nreq;
    int ncons;
    logic [31:0] tgt;
    lat_cfg = 1;
    do_reset(4);
    budget = 0;
    while (ins_valid_o !== 1'b1 && budget < 10) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      budget++;
    end
    checks++;
    if (ins_valid_o !== 1'b1 || !(mem_busy && mem_cnt == 0)) begin
      errors++;
      $display("FAIL cap_setup: ins_valid_o=%b, no response due this cycle", ins_valid_o);
    end
    tgt = ($urandom() & 32'h0000_FFFC) | 32'h0001_0000;
    rc = cyc;
    nreq = req_q.size();
    ncons = cons_q.size();
    cycle(1'b1, 1'b1, tgt | 32'($urandom_range(3, 0)), 1'b1);
    checks++;
    if (ins_valid_o !== 1'b0) begin errors++; $display("FAIL cap_flush: ins_valid_o=%b want 0", ins_valid_o); end
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (req_q.size() <= nreq || req_q[nreq] !== tgt || req_cyc[nreq] != rc + 1) begin
      errors++;
      $display("FAIL cap_next_req: got %h at cycle %0d want %h at cycle %0d",
               req_q.size() > nreq ? req_q[nreq] : 32'hx,
               req_cyc.size() > nreq ? req_cyc[nreq] : -1, tgt, rc + 1);
    end
    checks++;
    if (cons_q.size() <= ncons || cons_q[ncons] !== {word(tgt), tgt + 32'd4}) begin
      errors++;
      $display("FAIL cap_target_word: got %h want %h",
               cons_q.size() > ncons ? cons_q[ncons] : 64'hx, {word(tgt), tgt + 32'd4});
    end
    checks++;
    if (mdl_err !== 0) begin errors++; $display("FAIL cap_model: %0d mismatches, last %s", mdl_err, mdl_msg); end
  endtask

  task automatic test_reset_midflight();
    int budget;
    int nreq;
    int ncons;
    lat_cfg = 2;
    do_reset(4);
    budget = 0;
    while (ins_valid_o !== 1'b1 && budget < 10) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
      budget++;
    end
    checks++;
    if (ins_valid_o !== 1'b1) begin errors++; $display("FAIL rstmid_setup: ins_valid_o=%b want 1", ins_valid_o); end
    nreq = req_q.size();
    ncons = cons_q.size();
    #2;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if ({ins_o, next_addr_o, ins_valid_o, imem_req_o} !== 66'h0) begin
      errors++;
      $display("FAIL rstmid_async_clear: got ins %h next %h vld %b req %b want all 0",
               ins_o, next_addr_o, ins_valid_o, imem_req_o);
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    checks++;
    if (req_q.size() <= nreq || req_q[nreq] !== RST_PC) begin
      errors++;
      $display("FAIL rstmid_first_req: got %h want %h",
               req_q.size() > nreq ? req_q[nreq] : 32'hx, RST_PC);
    end
    checks++;
    if (cons_q.size() <= ncons || cons_q[ncons] !== {word(RST_PC), RST_PC + 32'd4}) begin
      errors++;
      $display("FAIL rstmid_first_word: got %h want %h",
               cons_q.size() > ncons ? cons_q[ncons] : 64'hx, {word(RST_PC), RST_PC + 32'd4});
    end
    checks++;
    if (mdl_err !== 0) begin errors++; $display("FAIL rstmid_model: %0d mismatches, last %s", mdl_err, mdl_msg); end
  endtask

  task automatic test_random();
    int bad;
    lat_rand = 1'b1;
    do_reset(4);
    for (int i = 0; i < 400; i++)
      cycle(($urandom() % 10) < 3, ($urandom() % 25) == 0, $urandom(), 1'b1);
    bad = 0;
    for (int k = 0; k < cons_q.size(); k++)
      if (cons_q[k][63:32] !== word(cons_q[k][31:0] - 32'd4)) bad++;
    checks++;
    if (cons_q.size() < 20 || bad != 0) begin
      errors++;
      $display("FAIL random_words: got %0d consumed %0d wrong, want >=20 and 0 wrong", cons_q.size(), bad);
    end
    checks++;
    if (mdl_err !== 0) begin errors++; $display("FAIL random_model: %0d mismatches, last %s", mdl_err, mdl_msg); end
    lat_rand = 1'b0;
  endtask

  initial begin
    salt = $urandom();
    test_reset();
    test_stream();
    test_latency3();
    test_stall();
    test_redirect_drain();
    test_redirect_capture();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage pipeline.
- Owns the PC and issues requests to instruction memory. Buffers returned words in a 2-entry FIFO.
- Presents {instruction, PC+4} to the IF/ID pipeline register, which captures on the falling clock edge and holds when stalled.
- Honours the hazard-unit stall and the branch/jump redirect from later stages, and discards stale memory responses after a redirect.

Parameters:
- ADDRWIDTH, 32, PC and memory address width (byte address).
- WIDTH, 32, instruction width.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- stall_i  in  1  IF/ID keep; head entry not consumed this cycle.
- redirect_i  in  1  branch/jump taken; one-cycle pulse.
- redirect_addr_i  in  ADDRWIDTH  new PC; bits[1:0] ignored (forced 0).
- imem_req_o  out  1  one-cycle request pulse.
- imem_addr_o  out  ADDRWIDTH  request address, valid when imem_req_o=1.
- imem_valid_i  in  1  response strobe; ≥1 cycle after request, in order, max 1 outstanding.
- imem_rdata_i  in  WIDTH  instruction word, valid with imem_valid_i.
- ins_o  out  WIDTH  head instruction; 0 (NOP) when empty.
- next_addr_o  out  ADDRWIDTH  head instruction address + 4; 0 when empty.
- ins_valid_o  out  1  FIFO non-empty.

Behaviour:
- Reset (async, any state):
  - pc_q=RESET_PC, FIFO empty, state=IDLE.
  - ins_o=0, next_addr_o=0, ins_valid_o=0, imem_req_o=0.
- Outputs are driven from FIFO head registers. Empty ⇒ NOP/0, so IF/ID latches a bubble directly.
- consume = ins_valid_o & ~stall_i & ~redirect_i. On consume, the head pops on the next rising edge.
- capture = imem_valid_i in state WAIT & ~redirect_i. Pushes {imem_rdata_i, pc_q+4}. pc_q <= pc_q+4, wrapping mod 2^ADDRWIDTH.
- occ_next = occupancy − consume + capture (0..2). capture into a full FIFO is impossible by construction; the bench asserts on it.
- issue_ok = occ_next ≤ 1 & ~redirect_i. This reserves a slot for the in-flight response.
- States:
  - IDLE: req=0. Next cycle → ISSUE.
  - ISSUE: req=issue_ok, addr=pc_q. If req=1 → WAIT, else stay in ISSUE.
  - WAIT: outstanding request.
    - On capture: if issue_ok, req=1 in the same cycle with addr=pc_q+4 (back-to-back), stay WAIT; else → ISSUE.
    - No response: stay WAIT.
  - DRAIN: stale request outstanding; req=0. On imem_valid_i, drop the data → ISSUE.
- Throughput: 1 instruction/cycle with 1-cycle memory when not stalled.
- Redirect (highest priority, any state except IDLE):
  - FIFO cleared; ins_valid_o=0 on the next cycle.
  - pc_q <= {redirect_addr_i[ADDRWIDTH-1:2],2'b00}.
  - imem_req_o=0 in the redirect cycle.
  - WAIT without imem_valid_i → DRAIN.
  - WAIT with imem_valid_i in the same cycle → data dropped, → ISSUE.
  - ISSUE stays in ISSUE. DRAIN stays in DRAIN with pc_q updated.
- Redirect in IDLE: pc_q updated, → ISSUE.
- Stall with full FIFO: no requests issued; head and outputs stable.
- Simultaneous consume + capture with occupancy 2 can only occur if issue_ok was violated; not reachable.
- Reset mid-request: a late imem_valid_i arriving in IDLE/ISSUE is ignored.

Decomposition:
- Shared package (cpu_defs):
  - ADDRWIDTH and WIDTH defines.
  - NOP_INSTR = {OP_WIDTH'b000000, 26'b0}.
  - Fetch state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DRAIN=2'd3.
- Sub-module fetch_buf:
  - 2-entry FIFO of {ins, next_addr}.
  - Inputs: push, pop, clear.
  - Outputs: head, occupancy, with async reset.
- The top level holds the FSM, pc_q and issue logic.

Test Plan:
1. Reset release, 1-cycle memory, stall_i=0 → requests at 0x0, 0x4, 0x8 on consecutive cycles; ins_o follows the data words; next_addr_o = 0x4, 0x8, 0xC; ins_valid_o held high.
2. 3-cycle memory latency → one request every 3 cycles. ins_valid_o pulses once per fetch when consumed immediately, else queues up to 2. next_addr_o is correct for each.
3. stall_i=1 for 5 cycles after the first word → FIFO fills to 2, then imem_req_o stays 0. ins_o is stable at the first word. After release, words pop in order with no loss or duplicate.
4. redirect_i with redirect_addr_i=0x103 while a 3-cycle request to 0x8 is in flight → FSM enters DRAIN and the 0x8 response is discarded. Next request is to 0x100; next_addr_o=0x104. ins_valid_o=0 in between.
5. redirect_i coincident with imem_valid_i, FIFO holding 1 entry → FIFO empties and data is dropped. Next request goes to the target in the following cycle.
6. rst_n_i pulsed low while in WAIT, response arriving 1 cycle after release → outputs 0 immediately (async). Stale response ignored; first new request is to RESET_PC.
